group_vec_unpacker: RTL and testbench

//  Receive side of the grouped Vec-of-bundles link. Accepts the 126-bit packed word as
//  NUM_BEATS beats over a valid/ready stream and reassembles it. Unpacks the word into the
//  2-element Vec fields {a, bar[2]{c,d}, b} and presents them on one valid/ready output.

---
 rtl/group_vec_pkg.sv | 38 +++
 rtl/group_vec_field_split.sv | 41 ++++
 rtl/group_vec_unpacker.sv | 141 ++++++++++++++
 tb/tb_group_vec_unpacker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/group_vec_pkg.sv
// Shared definitions for the grouped Vec-of-bundles link: field widths,
// packed-word geometry, field offsets and the per-element bundle struct.
// The packer and unpacker sides both import this package.
package group_vec_pkg;

    localparam int A_W    = 10;
    localparam int B_W    = 11;
    localparam int D_W    = 20;
    localparam int BAR_W  = D_W + 1;
    localparam int ELEM_W = A_W + B_W + 2 * BAR_W;
    localparam int WORD_W = 2 * ELEM_W;

    // Field offsets inside one element (LSB first).
    localparam int B_OFF      = 0;
    localparam int BAR0_D_OFF = B_W;
    localparam int BAR0_C_OFF = B_W + D_W;
    localparam int BAR1_D_OFF = B_W + BAR_W;
    localparam int BAR1_C_OFF = B_W + BAR_W + D_W;
    localparam int A_OFF      = B_W + 2 * BAR_W;

    typedef struct packed {
        logic           c;
        logic [D_W-1:0] d;
    } group_bar_t;

    // MSB-first declaration, so b lands at bit 0 and a at the top.
    typedef struct packed {
        logic [A_W-1:0]   a;
        group_bar_t [1:0] bar;
        logic [B_W-1:0]   b;
    } group_elem_t;

    // Extract element idx of a packed word.
    function automatic group_elem_t elem_at(input logic [WORD_W-1:0] word, input int idx);
        return group_elem_t'(word[idx * ELEM_W +: ELEM_W]);
    endfunction

endpackage

// File: rtl/group_vec_field_split.sv
// Pure wiring: splits a packed WORD_W word into the per-field ports of
// both Vec elements.
module group_vec_field_split
    import group_vec_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [A_W-1:0]    o_a_0,
    output logic [A_W-1:0]    o_a_1,
    output logic [B_W-1:0]    o_b_0,
    output logic [B_W-1:0]    o_b_1,
    output logic              o_bar_c_0_0,
    output logic              o_bar_c_0_1,
    output logic              o_bar_c_1_0,
    output logic              o_bar_c_1_1,
    output logic [D_W-1:0]    o_bar_d_0_0,
    output logic [D_W-1:0]    o_bar_d_0_1,
    output logic [D_W-1:0]    o_bar_d_1_0,
    output logic [D_W-1:0]    o_bar_d_1_1
);

    group_elem_t w_elem_0;
    group_elem_t w_elem_1;

    assign w_elem_0 = elem_at(i_word, 0);
    assign w_elem_1 = elem_at(i_word, 1);

    assign o_a_0       = w_elem_0.a;
    assign o_b_0       = w_elem_0.b;
    assign o_bar_c_0_0 = w_elem_0.bar[0].c;
    assign o_bar_d_0_0 = w_elem_0.bar[0].d;
    assign o_bar_c_0_1 = w_elem_0.bar[1].c;
    assign o_bar_d_0_1 = w_elem_0.bar[1].d;

    assign o_a_1       = w_elem_1.a;
    assign o_b_1       = w_elem_1.b;
    assign o_bar_c_1_0 = w_elem_1.bar[0].c;
    assign o_bar_d_1_0 = w_elem_1.bar[0].d;
    assign o_bar_c_1_1 = w_elem_1.bar[1].c;
    assign o_bar_d_1_1 = w_elem_1.bar[1].d;

endmodule

// File: rtl/group_vec_unpacker.sv
// Receive side of the grouped Vec-of-bundles link. Collects NUM_BEATS beats
// into an assembly buffer, loads the completed word into an output register
// and presents it as per-field ports behind a valid/ready handshake.
// Framing violations drop the frame and pulse frame_err for one cycle.
module group_vec_unpacker
    import group_vec_pkg::*;
#(
    parameter int NUM_BEATS = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W/NUM_BEATS-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [A_W-1:0]                out_a_0,
    output logic [A_W-1:0]                out_a_1,
    output logic [B_W-1:0]                out_b_0,
    output logic [B_W-1:0]                out_b_1,
    output logic                          out_bar_c_0_0,
    output logic                          out_bar_c_0_1,
    output logic                          out_bar_c_1_0,
    output logic                          out_bar_c_1_1,
    output logic [D_W-1:0]                out_bar_d_0_0,
    output logic [D_W-1:0]                out_bar_d_0_1,
    output logic [D_W-1:0]                out_bar_d_1_0,
    output logic [D_W-1:0]                out_bar_d_1_1,
    output logic                          frame_err
);

    localparam int BEAT_W    = WORD_W / NUM_BEATS;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int LAST_SLOT = (NUM_BEATS - 1) * BEAT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

    generate
        if ((WORD_W % NUM_BEATS) != 0) begin : g_bad_num_beats
            $error("group_vec_unpacker: WORD_W must be a multiple of NUM_BEATS");
        end
    endgenerate

    logic [CNT_W-1:0]  r_beat_cnt;
    logic [WORD_W-1:0] r_buf;
    logic [WORD_W-1:0] r_out_word;
    logic              r_out_valid;
    logic              r_frame_err;

    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [WORD_W-1:0] w_buf_nxt;
    logic [WORD_W-1:0] w_word_nxt;
    logic [WORD_W-1:0] w_load_word;
    logic              w_valid_nxt;
    logic              w_err_nxt;
    logic              w_at_last;
    logic              w_in_ready;
    logic              w_fire;

    // The last slot may be taken only once the held frame can be replaced;
    // earlier slots keep flowing while the output is stalled.
    assign w_at_last  = (r_beat_cnt == LAST_CNT);
    assign w_in_ready = ~w_at_last | ~r_out_valid | out_ready;
    assign w_fire     = in_valid & w_in_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;

    // Complete word: buffered beats below, the current beat in the top slot.
    always_comb begin
        w_load_word = r_buf;
        w_load_word[LAST_SLOT +: BEAT_W] = in_data;
    end

    // Next-state for counter, buffer, output register, valid and error pulse.
    always_comb begin
        w_cnt_nxt  = r_beat_cnt;
        w_buf_nxt  = r_buf;
        w_word_nxt = r_out_word;
        w_err_nxt  = 1'b0;

        if (r_out_valid & out_ready) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_out_valid;
        end

        if (w_fire) begin
            if (w_at_last & in_last) begin
                // Load wins over a same-cycle retire.
                w_word_nxt  = w_load_word;
                w_valid_nxt = 1'b1;
                w_cnt_nxt   = '0;
            end else if (w_at_last | in_last) begin
                // Early or missing in_last: drop the frame, output untouched.
                w_err_nxt = 1'b1;
                w_cnt_nxt = '0;
            end else begin
                w_buf_nxt[int'(r_beat_cnt) * BEAT_W +: BEAT_W] = in_data;
                w_cnt_nxt = r_beat_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_nxt = r_beat_cnt;
        end
    end

    // State registers; reset discards partial beats and any held frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_beat_cnt  <= '0;
            r_buf       <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_beat_cnt  <= w_cnt_nxt;
            r_buf       <= w_buf_nxt;
            r_out_word  <= w_word_nxt;
            r_out_valid <= w_valid_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    group_vec_field_split u_field_split (
        .i_word      (r_out_word),
        .o_a_0       (out_a_0),
        .o_a_1       (out_a_1),
        .o_b_0       (out_b_0),
        .o_b_1       (out_b_1),
        .o_bar_c_0_0 (out_bar_c_0_0),
        .o_bar_c_0_1 (out_bar_c_0_1),
        .o_bar_c_1_0 (out_bar_c_1_0),
        .o_bar_c_1_1 (out_bar_c_1_1),
        .o_bar_d_0_0 (out_bar_d_0_0),
        .o_bar_d_0_1 (out_bar_d_0_1),
        .o_bar_d_1_0 (out_bar_d_1_0),
        .o_bar_d_1_1 (out_bar_d_1_1)
    );

endmodule

// File: tb/tb_group_vec_unpacker.sv
// Self-checking bench for group_vec_unpacker: directed scenarios followed by
// randomized traffic, checked against a beat-queue reference model.
module tb_group_vec_unpacker;
    import group_vec_pkg::*;

    localparam int NB = 3;
    localparam int BW = WORD_W / NB;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [BW-1:0]   in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [A_W-1:0]  out_a_0, out_a_1;
    logic [B_W-1:0]  out_b_0, out_b_1;
    logic            out_bar_c_0_0, out_bar_c_0_1, out_bar_c_1_0, out_bar_c_1_1;
    logic [D_W-1:0]  out_bar_d_0_0, out_bar_d_0_1, out_bar_d_1_0, out_bar_d_1_1;
    logic            frame_err;

    int checks = 0;
    int errors = 0;

    // Reference model: beats of the frame in progress, and the output word.
    logic [BW-1:0]     m_beats[$];
    logic              m_valid;
    logic [WORD_W-1:0] m_word;
    logic              m_err;

    group_vec_unpacker #(.NUM_BEATS(NB)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a_0(out_a_0), .out_a_1(out_a_1), .out_b_0(out_b_0), .out_b_1(out_b_1),
        .out_bar_c_0_0(out_bar_c_0_0), .out_bar_c_0_1(out_bar_c_0_1),
        .out_bar_c_1_0(out_bar_c_1_0), .out_bar_c_1_1(out_bar_c_1_1),
        .out_bar_d_0_0(out_bar_d_0_0), .out_bar_d_0_1(out_bar_d_0_1),
        .out_bar_d_1_0(out_bar_d_1_0), .out_bar_d_1_1(out_bar_d_1_1),
        .frame_err(frame_err)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // DUT field ports reassembled in the link's documented bit layout.
    function automatic logic [WORD_W-1:0] obs_word();
        return {out_a_1, out_bar_c_1_1, out_bar_d_1_1, out_bar_c_1_0, out_bar_d_1_0, out_b_1,
                out_a_0, out_bar_c_0_1, out_bar_d_0_1, out_bar_c_0_0, out_bar_d_0_0, out_b_0};
    endfunction

    function automatic logic [BW-1:0] rnd_beat();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[BW-1:0];
    endfunction

    // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
    task automatic step(input logic v, input logic [BW-1:0] d, input logic l, input logic ordy);
        logic              exp_rdy;
        logic [WORD_W-1:0] w;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        exp_rdy = (m_beats.size() != NB - 1) || !m_valid || ordy;
        check_val("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
        m_err = 1'b0;
        if (m_valid && ordy) m_valid = 1'b0;
        if (v && exp_rdy) begin
            if (l && m_beats.size() == NB - 1) begin
                w = '0;
                for (int k = 0; k < NB - 1; k++) w = w | (WORD_W'(m_beats[k]) << (k * BW));
                w = w | (WORD_W'(d) << ((NB - 1) * BW));
                m_word  = w;
                m_valid = 1'b1;
                m_beats.delete();
            end else if (l || m_beats.size() == NB - 1) begin
                m_err = 1'b1;
                m_beats.delete();
            end else begin
                m_beats.push_back(d);
            end
        end
        @(posedge clock);
        #1;
        check_val("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
        check_val("frame_err", {127'd0, frame_err}, {127'd0, m_err});
        check_val("fields", {2'd0, obs_word()}, {2'd0, m_word});
    endtask

    task automatic frame(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                         input logic [BW-1:0] b2, input logic ordy);
        step(1'b1, b0, 1'b0, ordy);
        step(1'b1, b1, 1'b0, ordy);
        step(1'b1, b2, 1'b1, ordy);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        m_beats.delete();
        m_valid = 1'b0;
        m_word  = '0;
        m_err   = 1'b0;
        check_val("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check_val("rst_frame_err", {127'd0, frame_err}, 128'd0);
        check_val("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check_val("rst_fields", {2'd0, obs_word()}, 128'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [BW-1:0]     a0, a1, a2, b0, b1, b2;
        logic [WORD_W-1:0] saved;
        logic              v, l, ordy;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_valid   = 1'b0;
        m_word    = '0;
        m_err     = 1'b0;
        @(posedge clock);
        #1;
        do_reset();

        // Single frame with only b of element 0 set.
        frame(42'h1, 42'h0, 42'h0, 1'b1);
        check_val("t2_valid", {127'd0, out_valid}, 128'd1);
        check_val("t2_b0", {117'd0, out_b_0}, 128'd1);
        check_val("t2_a0", {118'd0, out_a_0}, 128'd0);
        step(1'b0, 42'h0, 1'b0, 1'b1);

        // Field boundaries.
        frame(42'h0_8000_0000, 42'h0, 42'h0, 1'b1);
        check_val("t3_c00", {127'd0, out_bar_c_0_0}, 128'd1);
        frame(42'h0, 42'h400, 42'h0, 1'b1);
        check_val("t3_c01", {127'd0, out_bar_c_0_1}, 128'd1);
        frame(42'h0, 42'h800, 42'h0, 1'b1);
        check_val("t3_a0", {118'd0, out_a_0}, 128'd1);
        frame(42'h0, 42'h0, 42'h200_0000_0000, 1'b1);
        check_val("t3_a1", {118'd0, out_a_1}, 128'h200);
        step(1'b0, 42'h0, 1'b0, 1'b1);

        // Backpressure: A held, B collects, B's last beat stalls then loads as A retires.
        a0 = rnd_beat(); a1 = rnd_beat(); a2 = rnd_beat();
        b0 = rnd_beat(); b1 = rnd_beat(); b2 = rnd_beat();
        frame(a0, a1, a2, 1'b0);
        saved = m_word;
        step(1'b1, b0, 1'b0, 1'b0);
        step(1'b1, b1, 1'b0, 1'b0);
        step(1'b1, b2, 1'b1, 1'b0);
        check_val("t4_stall", {127'd0, in_ready}, 128'd0);
        check_val("t4_holdA", {2'd0, obs_word()}, {2'd0, saved});
        step(1'b1, b2, 1'b1, 1'b1);
        check_val("t4_valid", {127'd0, out_valid}, 128'd1);
        check_val("t4_loadB", {2'd0, obs_word()}, {2'd0, b2, b1, b0});
        step(1'b0, 42'h0, 1'b0, 1'b1);

        // Early in_last, recovery, then missing in_last.
        step(1'b1, rnd_beat(), 1'b0, 1'b1);
        step(1'b1, rnd_beat(), 1'b1, 1'b1);
        check_val("t5_err1", {127'd0, frame_err}, 128'd1);
        check_val("t5_noval", {127'd0, out_valid}, 128'd0);
        step(1'b0, 42'h0, 1'b0, 1'b1);
        check_val("t5_pulse", {127'd0, frame_err}, 128'd0);
        frame(42'h5, 42'h6, 42'h7, 1'b1);
        check_val("t5_recov", {2'd0, obs_word()}, {2'd0, 42'h7, 42'h6, 42'h5});
        step(1'b0, 42'h0, 1'b0, 1'b1);
        saved = m_word;
        step(1'b1, rnd_beat(), 1'b0, 1'b1);
        step(1'b1, rnd_beat(), 1'b0, 1'b1);
        step(1'b1, rnd_beat(), 1'b0, 1'b1);
        check_val("t5_err2", {127'd0, frame_err}, 128'd1);
        check_val("t5_keep", {2'd0, obs_word()}, {2'd0, saved});

        // Streaming two back-to-back frames, then reset with a held frame.
        frame(rnd_beat(), rnd_beat(), rnd_beat(), 1'b1);
        check_val("t6_v1", {127'd0, out_valid}, 128'd1);
        frame(rnd_beat(), rnd_beat(), rnd_beat(), 1'b1);
        check_val("t6_v2", {127'd0, out_valid}, 128'd1);
        step(1'b1, rnd_beat(), 1'b0, 1'b0);
        do_reset();
        frame(42'h11, 42'h22, 42'h33, 1'b1);
        check_val("t6_after_rst", {2'd0, obs_word()}, {2'd0, 42'h33, 42'h22, 42'h11});

        // Randomized traffic with occasional framing faults and resets.
        for (int i = 0; i < 3000; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            l    = (m_beats.size() == NB - 1);
            if ($urandom_range(0, 15) == 0) l = !l;
            ordy = ($urandom_range(0, 3) != 0);
            step(v, rnd_beat(), l, ordy);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
